// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered write ack / overflow / underflow pulses and combinational status.
// Define SYNC_FIFO_ASSERTIONS_EN to compile the embedded SVA checks.
module sync_fifo #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] AfCnt    = CntW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_d;
    logic                  wr_accept, rd_accept;
    logic                  wr_ack_d, overflow_d, underflow_d;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        full        = (count_q == DepthCnt);
        empty       = (count_q == '0);
        almostfull  = (count_q == AfCnt);
        almostempty = (count_q == CntW'(1));
    end

    always_comb begin
        wr_accept   = wr_en && !full;
        rd_accept   = rd_en && !empty;

        wr_ptr_d    = wr_accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rd_accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        data_out_d  = rd_accept ? mem[rd_ptr_q] : data_out;

        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;

        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_out  <= data_out_d;
            wr_ack    <= wr_ack_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end

    // Storage is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ASSERTIONS_EN
    a_reset_outputs: assert property (@(posedge clk)
        !rst_n |-> (data_out == '0) && !wr_ack && !overflow);

    a_wr_ptr_step: assert property (@(posedge clk) disable iff (!rst_n)
        wr_accept |=> wr_ptr_q == (($past(wr_ptr_q) == LastPtr) ? '0 : $past(wr_ptr_q) + PtrW'(1)));

    a_rd_ptr_step: assert property (@(posedge clk) disable iff (!rst_n)
        rd_accept |=> rd_ptr_q == (($past(rd_ptr_q) == LastPtr) ? '0 : $past(rd_ptr_q) + PtrW'(1)));

    a_wr_ptr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !wr_accept |=> $stable(wr_ptr_q));

    a_rd_ptr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !rd_accept |=> $stable(rd_ptr_q));

    a_count_inc: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_accept && !rd_accept) |=> count_q == $past(count_q) + CntW'(1));

    a_count_dec: assert property (@(posedge clk) disable iff (!rst_n)
        (!wr_accept && rd_accept) |=> count_q == $past(count_q) - CntW'(1));

    a_count_same: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_accept == rd_accept) |=> $stable(count_q));

    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_ack && overflow));

    always_comb begin
        if (rst_n) begin
            a_count_max: assert (count_q <= DepthCnt);
            a_full:      assert (full == (count_q == DepthCnt));
            a_empty:     assert (empty == (count_q == '0));
            a_afull:     assert (almostfull == (count_q == AfCnt));
            a_aempty:    assert (almostempty == (count_q == CntW'(1)));
            a_full_empty: assert (!(full && empty));
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: the stimulus thread queues expected post-edge state,
// a monitor thread pops and compares one record per clock edge.
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ack;
        logic         ovf;
        logic         udf;
        logic         fl;
        logic         em;
        logic         af;
        logic         ae;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] model_q [$];
    logic [W-1:0] last_data = '0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the reference queue decides acceptance and expected outputs.
    task automatic step(input logic wr, input logic rd, input logic [W-1:0] din);
        exp_t e;
        int   cnt;
        logic wacc, racc;
        @(negedge clk);
        cnt  = model_q.size();
        wacc = wr && (cnt != D);
        racc = rd && (cnt != 0);
        if (racc) last_data = model_q.pop_front();
        if (wacc) model_q.push_back(din);
        cnt   = model_q.size();
        e.data = last_data;
        e.ack  = wacc;
        e.ovf  = wr && !wacc;
        e.udf  = rd && !racc;
        e.fl   = (cnt == D);
        e.em   = (cnt == 0);
        e.af   = (cnt == D - 1);
        e.ae   = (cnt == 1);
        exp_q.push_back(e);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " data_out"}, 32'(data_out), 32'h0);
        chk({tag, " wr_ack"}, 32'(wr_ack), 32'h0);
        chk({tag, " overflow"}, 32'(overflow), 32'h0);
        chk({tag, " empty"}, 32'(empty), 32'h1);
        chk({tag, " full"}, 32'(full), 32'h0);
    endtask

    // Monitor: one expected record per active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("wr_ack", 32'(wr_ack), 32'(e.ack));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("underflow", 32'(underflow), 32'(e.udf));
                chk("full", 32'(full), 32'(e.fl));
                chk("empty", 32'(empty), 32'(e.em));
                chk("almostfull", 32'(almostfull), 32'(e.af));
                chk("almostempty", 32'(almostempty), 32'(e.ae));
            end
        end
    end

    initial begin
        #1;
        check_reset_outputs("initial reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 1..8, then one rejected write.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, W'(i));
        step(1'b1, 1'b0, 16'h00FF);
        settle();
        chk("fill overflow", 32'(overflow), 32'h1);
        chk("fill full", 32'(full), 32'h1);

        // Drain, then one rejected read.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        settle();
        chk("drain underflow", 32'(underflow), 32'h1);
        chk("drain data hold", 32'(data_out), 32'h0008);

        // Simultaneous on empty: write only.
        step(1'b1, 1'b1, 16'h00A1);
        settle();
        chk("sim empty underflow", 32'(underflow), 32'h1);
        chk("sim empty almostempty", 32'(almostempty), 32'h1);

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h00B0 + W'(i));
        // Simultaneous on full: read only, count 7.
        step(1'b1, 1'b1, 16'h00C0);
        settle();
        chk("sim full overflow", 32'(overflow), 32'h1);
        chk("sim full almostfull", 32'(almostfull), 32'h1);
        chk("sim full data", 32'(data_out), 32'h00A1);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
        // Simultaneous at count 4: both proceed.
        step(1'b1, 1'b1, 16'h00D0);

        // Interleaved pairs walk both pointers around twice.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0100 + W'(i));
            step(1'b0, 1'b1, '0);
        end
        step(1'b1, 1'b0, 16'h0200);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 16'h0201);
        settle();
        chk("pre-reset wr_ack", 32'(wr_ack), 32'h1);

        // Asynchronous reset mid-traffic, away from any clock edge.
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        last_data = '0;

        // Contents discarded: the first word after reset is the only word.
        step(1'b1, 1'b0, 16'h55AA);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) chk("scoreboard drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
